// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared constants for the counter family: default widths, default prescale
// ratio, the wrap/saturate mode encoding and a helper that sizes the
// prescaler phase register.
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_PRESCALE = 1;

    // Behaviour at the count bounds.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

    // Width of a phase register that must hold 0..prescale-1.
    // A ratio of 1 still gets a one-bit register so the port widths stay legal.
    function automatic int phase_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage : counter_pkg

// File: rtl/count_prescaler.sv
// ---------------------------------------------------------------------------
// count_prescaler
// Divides the count enable by PRESCALE: tick is issued on the enabled cycle
// that completes a group of PRESCALE enabled cycles.
//
// Ports
//   clk   : clock, rising edge active
//   reset : asynchronous active-low reset, clears the phase
//   en    : enable; the phase advances only on enabled edges
//   clr   : synchronous phase clear (used by the parent's parallel load)
//   tick  : combinational, en AND phase at its last value
// ---------------------------------------------------------------------------
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              PW   = phase_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // With PRESCALE=1 LAST is 0 and phase never leaves 0, so tick follows en.
    assign tick = en && (phase == LAST);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end

endmodule : count_prescaler

// File: rtl/param_counter.sv
// ---------------------------------------------------------------------------
// param_counter
// Up/down modulo counter with parallel load, prescaled enable, selectable
// wrap or saturate at the bounds, terminal count and a sticky overflow flag.
//
// Parameters
//   WIDTH    : counter / data width (2..32)
//   MODULUS  : count range, MAX = MODULUS-1 (2..2**WIDTH)
//   PRESCALE : enabled cycles per count step (1..256)
//   SATURATE : MODE_WRAP (0) wraps at the bounds, MODE_SAT (1) holds
//
// Ports
//   clk     : clock, rising edge active
//   reset   : asynchronous active-low reset (out, ovf, prescaler phase -> 0)
//   load    : synchronous load strobe, highest priority; clamps data to MAX
//   data    : load value
//   en      : count enable into the prescaler
//   up      : direction, 1 = up, 0 = down
//   clr_ovf : synchronous clear of ovf (a simultaneous set wins)
//   out     : registered count
//   tc      : combinational terminal count (this edge wraps or saturates)
//   ovf     : registered sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module param_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = DEFAULT_WIDTH,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              PRESCALE = DEFAULT_PRESCALE,
    parameter int              SATURATE = int'(MODE_WRAP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // MODULUS may be 2**WIDTH, so the subtraction is done in 64 bits and the
    // result is guaranteed to fit WIDTH bits.
    localparam logic [WIDTH-1:0] MAX      = WIDTH'(MODULUS - 64'd1);
    localparam bit               SAT_MODE = (SATURATE == int'(MODE_SAT));

    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic             bound_hit;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    assign at_max    = (out == MAX);
    assign at_zero   = (out == '0);
    assign bound_hit = up ? at_max : at_zero;
    assign tc        = en && tick && bound_hit;

    // Out-of-range load values clamp to MAX so out never leaves 0..MAX.
    assign load_val = (data > MAX) ? MAX : data;

    // Next value for a count step. Increment/decrement only happen away from
    // the bound, so no intermediate value ever exceeds MAX.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        step_val = out;
        if (up) begin
            if (at_max) begin
                step_val = SAT_MODE ? MAX : '0;
            end else begin
                step_val = out + WIDTH'(1);
            end
        end else begin
            if (at_zero) begin
                step_val = SAT_MODE ? '0 : MAX;
            end else begin
                step_val = out - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else if (load) begin
            out <= load_val;
        end else if (tick) begin
            out <= step_val;
        end
    end

    // A load suppresses the step, so it also suppresses the overflow set.
    // Set has priority over clear on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (tc && !load) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule : param_counter

// File: tb/tb_param_counter.sv
// ---------------------------------------------------------------------------
// tb_param_counter
// Directed bench for param_counter. Four instances share the stimulus:
//   u_a : MODULUS=10, PRESCALE=1, wrap
//   u_b : MODULUS=10, PRESCALE=1, saturate
//   u_c : MODULUS=256, PRESCALE=1, wrap
//   u_d : MODULUS=10, PRESCALE=4, wrap
// Each section checks only the instance it targets. Inputs change 1 ns after
// a rising edge; registered outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_param_counter;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] data;
    logic       en;
    logic       up;
    logic       clr_ovf;

    logic [7:0] out_a, out_b, out_c, out_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;

    int n_checks = 0;
    int n_errors = 0;

    param_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
        .clr_ovf(clr_ovf), .out(out_a), .tc(tc_a), .ovf(ovf_a)
    );

    param_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_b (
        .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
        .clr_ovf(clr_ovf), .out(out_b), .tc(tc_b), .ovf(ovf_b)
    );

    param_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) u_c (
        .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
        .clr_ovf(clr_ovf), .out(out_c), .tc(tc_c), .ovf(ovf_c)
    );

    param_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) u_d (
        .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
        .clr_ovf(clr_ovf), .out(out_d), .tc(tc_d), .ovf(ovf_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset across one edge with idle inputs, released between edges.
    task automatic do_reset();
        load    = 1'b0;
        en      = 1'b0;
        clr_ovf = 1'b0;
        reset   = 1'b0;
        step();
        #2 reset = 1'b1;
        step();
    endtask

    initial begin
        int exp_a;

        reset   = 1'b0;
        load    = 1'b0;
        data    = 8'd0;
        en      = 1'b0;
        up      = 1'b1;
        clr_ovf = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_out", out_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_tc",  tc_a,  0);
        step();
        #2 reset = 1'b1;
        step();

        // ---- wrap: 12 up ticks, MODULUS=10 ----
        en    = 1'b1;
        up    = 1'b1;
        exp_a = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            check($sformatf("wrap_tc_%0d", i), tc_a, (exp_a == 9) ? 1 : 0);
            step();
            exp_a = (exp_a + 1) % 10;
            check($sformatf("wrap_out_%0d", i), out_a, exp_a);
            if (i == 9) check("wrap_ovf_before", ovf_a, 0);
        end
        check("wrap_ovf_after", ovf_a, 1);

        // ---- load clamps to MAX ----
        en   = 1'b0;
        load = 1'b1;
        data = 8'd200;
        step();
        load = 1'b0;
        check("load_clamp", out_a, 9);

        // ---- async reset between edges ----
        load = 1'b1;
        data = 8'd5;
        step();
        load = 1'b0;
        check("pre_rst_out", out_a, 5);
        check("load_keeps_ovf", ovf_a, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", out_a, 0);
        check("async_rst_ovf", ovf_a, 0);
        step();
        #2 reset = 1'b1;
        en = 1'b1;
        up = 1'b1;
        step();
        check("restart_out", out_a, 1);
        en = 1'b0;

        // ---- saturate ----
        do_reset();
        load = 1'b1;
        data = 8'd8;
        step();
        load = 1'b0;
        check("sat_load", out_b, 8);
        en = 1'b1;
        up = 1'b1;
        step();
        check("sat_up1", out_b, 9);
        check("sat_ovf_clear", ovf_b, 0);
        #1;
        check("sat_tc", tc_b, 1);
        step();
        check("sat_up2", out_b, 9);
        step();
        check("sat_up3", out_b, 9);
        check("sat_ovf", ovf_b, 1);
        up = 1'b0;
        step();
        check("sat_dn1", out_b, 8);
        step();
        check("sat_dn2", out_b, 7);
        en = 1'b0;

        // ---- underflow at full 8-bit range, set beats clear ----
        do_reset();
        load = 1'b1;
        data = 8'd0;
        step();
        load = 1'b0;
        up = 1'b0;
        en = 1'b1;
        #1;
        check("uf_tc", tc_c, 1);
        step();
        check("uf_out", out_c, 255);
        check("uf_ovf", ovf_c, 1);
        en   = 1'b0;
        load = 1'b1;
        data = 8'd0;
        step();
        load = 1'b0;
        check("uf_reload", out_c, 0);
        en      = 1'b1;
        clr_ovf = 1'b1;
        step();
        check("uf2_out", out_c, 255);
        check("set_wins", ovf_c, 1);
        en = 1'b0;
        step();
        check("clr_ovf", ovf_c, 0);
        clr_ovf = 1'b0;

        // ---- prescale by 4 ----
        do_reset();
        en = 1'b1;
        up = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("ps_out_%0d", i), out_d, i / 4);
        end
        step();
        step();
        check("ps_mid", out_d, 2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ps_hold_%0d", i), out_d, 2);
        end
        en = 1'b1;
        step();
        check("ps_resume1", out_d, 2);
        step();
        check("ps_resume2", out_d, 3);

        // ---- load with en: load wins, phase cleared ----
        step();
        step();
        load = 1'b1;
        data = 8'd5;
        step();
        load = 1'b0;
        check("ld_en_out", out_d, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ld_phase_%0d", i), out_d, 5);
        end
        step();
        check("ld_phase_tick", out_d, 6);
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_param_counter

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which is the counter and data width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 2**WIDTH, which is the count range; MAX = MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 The block SHALL have parameter PRESCALE, default 1, which is the number of enabled cycles per count step (legal range 1..256).
REQ-004 The block SHALL have parameter SATURATE, default 0, selecting wrap at the bounds when 0 and hold at the bounds when 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port data, input, WIDTH bits: the load value.
REQ-009 The block SHALL have port en, input, 1 bit: count enable, fed to the prescaler.
REQ-010 The block SHALL have port up, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-011 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of the sticky overflow flag.
REQ-012 The block SHALL have port out, output, WIDTH bits: the registered count value.
REQ-013 The block SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky overflow/underflow flag, registered.

Function
REQ-015 Priority per rising edge SHALL be: load, then count step; reset overrides all asynchronously.
REQ-016 When load=1, out SHALL become min(data, MAX) after that edge (1-cycle latency); the prescaler phase SHALL be cleared; ovf SHALL be unaffected.
REQ-017 The prescaler SHALL increment its phase on each edge with en=1 and load=0, and SHALL issue tick when phase==PRESCALE-1 and en=1, then return to 0; with PRESCALE=1, tick=en.
REQ-018 When en=0, the prescaler phase and out SHALL hold.
REQ-019 On tick with up=1 and out<MAX, out SHALL become out+1; on tick with up=0 and out>0, out SHALL become out-1.
REQ-020 On tick with up=1 and out==MAX, out SHALL become 0 when SATURATE=0, out SHALL hold MAX when SATURATE=1, and ovf SHALL be set in both cases.
REQ-021 On tick with up=0 and out==0, out SHALL become MAX when SATURATE=0, out SHALL hold 0 when SATURATE=1, and ovf SHALL be set in both cases.
REQ-022 tc SHALL equal en AND tick-pending AND ((up AND out==MAX) OR (NOT up AND out==0)); that is, it is asserted in the cycle whose edge wraps or saturates.
REQ-023 ovf SHALL remain set until an edge with clr_ovf=1; if set and clear occur on the same edge, set SHALL win.
REQ-024 A change of up between ticks SHALL take effect on the next tick with no extra latency; the prescaler phase SHALL be retained.
REQ-025 Arithmetic SHALL be unsigned WIDTH bits; no intermediate value SHALL exceed MAX.

Reset
REQ-026 While reset=0, the block SHALL force out=0, ovf=0 and prescaler phase=0 immediately, without waiting for clk.
REQ-027 Reset asserted mid-prescale or mid-load SHALL discard the pending step; the first edge after deassertion SHALL be evaluated normally.

Structure
REQ-028 The block SHALL keep shared constants (default WIDTH, default PRESCALE, mode encoding WRAP=0/SAT=1) in the team package counter_pkg.
REQ-029 The block SHALL contain one sub-module, count_prescaler (parameter PRESCALE; ports clk, reset, en, clr, tick), instantiated once.

Verification
REQ-030 WIDTH=8, MODULUS=10, PRESCALE=1, SATURATE=0: reset, then up=1 with en=1 for 12 cycles -> out runs 1..9,0,1,2; tc high in the cycle with out=9; ovf=1 after the wrap.
REQ-031 Same configuration with SATURATE=1: load 8, then up=1 for 3 ticks -> out 9,9,9; ovf=1; then down 2 ticks -> out 8,7.
REQ-032 WIDTH=8, MODULUS=256: load data=0, up=0, one tick -> out=255, ovf=1; clr_ovf=1 together with another underflow tick -> ovf stays 1.
REQ-033 PRESCALE=4: en=1 continuously -> out increments every 4th edge; en dropped for 3 cycles mid-phase -> the phase is held and the step resumes after the remaining enabled cycles.
REQ-034 MODULUS=10: load data=200 -> out=9; load and en together -> the load wins and the prescaler phase is cleared.
REQ-035 Assert reset between clk edges while out=5 -> out=0 and ovf=0 before the next edge; deassert -> counting restarts from 0.
